// File: rtl/rca_sum_accumulator.sv
// rca_sum_accumulator
//   Downstream stage of the 4-bit ripple carry adder. Accepts adder results
//   ({in_cout,in_sum}) over a valid/ready handshake, sums NUM_SAMPLES of them
//   into an ACC_W-bit running total, then presents that frame total with a
//   sticky overflow flag over an output valid/ready handshake.
//
//   Build option: define SATURATE_EN to clamp the total at all-ones on
//   overflow. When it is undefined, the total wraps modulo 2^ACC_W.
//   out_overflow is set in both builds.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clear               synchronous frame abort; highest priority
//   in_valid/in_ready   input handshake; in_ready is decoded from registered state only
//   in_sum, in_cout     adder result; operand = zero-extended {in_cout,in_sum}
//   out_valid/out_ready output handshake for the frame total
//   out_acc             frame total (qualified by out_valid)
//   out_overflow        total passed 2^ACC_W-1 during the frame (qualified by out_valid)
module rca_sum_accumulator #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ACC_W       = 12,
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_overflow
);

  localparam int unsigned CntW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e           r_state, w_state_next;
  logic             r_live;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [CntW-1:0]  r_cnt, w_cnt_next;
  logic             r_ovf, w_ovf_next;
  logic             r_out_valid, w_out_valid_next;
  logic             w_accept;
  logic             w_last;
  logic [ACC_W:0]   w_sum;

  // r_live holds in_ready low until the first edge after reset release.
  assign in_ready = r_live && (r_state != StHold);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LastCnt);
  // One extra bit catches the carry out of bit ACC_W-1.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_cnt_next       = r_cnt;
    w_ovf_next       = r_ovf;
    w_out_valid_next = r_out_valid;
    if (clear) begin
      // Abort the frame; any beat accepted this cycle is discarded.
      w_state_next     = StIdle;
      w_acc_next       = '0;
      w_cnt_next       = '0;
      w_ovf_next       = 1'b0;
      w_out_valid_next = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StAccum: begin
          if (w_accept) begin
`ifdef SATURATE_EN
            if (r_ovf || w_sum[ACC_W]) begin
              w_acc_next = '1;
              w_ovf_next = 1'b1;
            end else begin
              w_acc_next = w_sum[ACC_W-1:0];
            end
`else
            w_acc_next = w_sum[ACC_W-1:0];
            w_ovf_next = r_ovf | w_sum[ACC_W];
`endif
            w_cnt_next = r_cnt + CntW'(1);
            if (w_last) begin
              w_state_next     = StHold;
              w_out_valid_next = 1'b1;
            end else begin
              w_state_next = StAccum;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            w_state_next     = StIdle;
            w_acc_next       = '0;
            w_cnt_next       = '0;
            w_ovf_next       = 1'b0;
            w_out_valid_next = 1'b0;
          end
        end
        default: begin
          w_state_next     = StIdle;
          w_acc_next       = '0;
          w_cnt_next       = '0;
          w_ovf_next       = 1'b0;
          w_out_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_live      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_live      <= 1'b1;
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_ovf       <= w_ovf_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  // The accumulator register is the output; it only carries a frame total while out_valid is high.
  assign out_valid    = r_out_valid;
  assign out_acc      = r_acc;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_rca_sum_accumulator.sv
module tb_rca_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_cout = 1'b0;
  logic [3:0] in_sum = '0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_ovf;
  logic [7:0] a_acc;
  logic       b_in_ready, b_out_valid, b_ovf;
  logic [5:0] b_acc;

  logic       c_clear = 1'b0;
  logic       c_valid = 1'b0;
  logic       c_cout = 1'b0;
  logic [3:0] c_sum = '0;
  logic       c_ready_out = 1'b0;
  logic       c_in_ready, c_out_valid, c_ovf;
  logic [7:0] c_acc;

  int total = 0;
  int bad = 0;

  // dut_a and dut_b share stimulus; they differ only in accumulator width.
  rca_sum_accumulator #(.DATA_W(4), .ACC_W(8), .NUM_SAMPLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_acc(a_acc), .out_overflow(a_ovf)
  );

  rca_sum_accumulator #(.DATA_W(4), .ACC_W(6), .NUM_SAMPLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_acc(b_acc), .out_overflow(b_ovf)
  );

  rca_sum_accumulator #(.DATA_W(4), .ACC_W(8), .NUM_SAMPLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_valid), .in_ready(c_in_ready),
    .in_sum(c_sum), .in_cout(c_cout), .out_valid(c_out_valid), .out_ready(c_ready_out),
    .out_acc(c_acc), .out_overflow(c_ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_acc(input int s, input int w);
    int lim;
    lim = (1 << w) - 1;
`ifdef SATURATE_EN
    return (s > lim) ? lim : s;
`else
    return s & lim;
`endif
  endfunction

  // Frame model for the 4-sample instances: exact integer total plus beat count.
  logic m_live = 1'b0;
  logic m_hold = 1'b0;
  int   m_n = 0;
  int   m_sum = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live <= 1'b0;
      m_hold <= 1'b0;
      m_n    <= 0;
      m_sum  <= 0;
    end else begin
      m_live <= 1'b1;
      if (clear) begin
        m_hold <= 1'b0;
        m_n    <= 0;
        m_sum  <= 0;
      end else if (m_hold) begin
        if (out_ready) begin
          m_hold <= 1'b0;
          m_n    <= 0;
          m_sum  <= 0;
        end
      end else if (in_valid && m_live) begin
        m_sum <= m_sum + int'({in_cout, in_sum});
        m_n   <= m_n + 1;
        if (m_n + 1 == 4) m_hold <= 1'b1;
      end
    end
  end

  // Single-sample model: each accepted operand must come back out exactly once.
  logic mc_live = 1'b0;
  logic mc_hold = 1'b0;
  int   mc_val = 0;
  int   mc_accepts = 0;
  int   c_outs = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_live <= 1'b0;
      mc_hold <= 1'b0;
    end else begin
      mc_live <= 1'b1;
      if (mc_hold) begin
        if (c_ready_out) mc_hold <= 1'b0;
      end else if (c_valid && mc_live) begin
        mc_val     <= int'({c_cout, c_sum});
        mc_hold    <= 1'b1;
        mc_accepts <= mc_accepts + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && c_out_valid && c_ready_out) c_outs <= c_outs + 1;
  end

  always @(negedge clk) begin
    chk("a_in_ready", int'(a_in_ready), int'(m_live && !m_hold));
    chk("a_out_valid", int'(a_out_valid), int'(m_hold));
    chk("b_in_ready", int'(b_in_ready), int'(m_live && !m_hold));
    chk("b_out_valid", int'(b_out_valid), int'(m_hold));
    if (m_hold || !rst_n) begin
      chk("a_out_acc", int'(a_acc), exp_acc(m_sum, 8));
      chk("a_out_overflow", int'(a_ovf), int'(m_sum > 255));
      chk("b_out_acc", int'(b_acc), exp_acc(m_sum, 6));
      chk("b_out_overflow", int'(b_ovf), int'(m_sum > 63));
    end
    chk("c_in_ready", int'(c_in_ready), int'(mc_live && !mc_hold));
    chk("c_out_valid", int'(c_out_valid), int'(mc_hold));
    if (mc_hold) begin
      chk("c_out_acc", int'(c_acc), mc_val);
      chk("c_out_overflow", int'(c_ovf), 0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input logic co, input logic [3:0] s);
    in_valid = 1'b1;
    in_cout  = co;
    in_sum   = s;
    step();
  endtask

  initial begin
    repeat (2) step();
    chk("reset_valid", int'(a_out_valid), 0);
    chk("reset_acc", int'(a_acc), 0);
    chk("reset_in_ready", int'(a_in_ready), 0);
    rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", int'(a_in_ready), 1);

    // Frame 0x05 + 0x0C + 0x15 + 0x1F = 69, held with out_ready low.
    out_ready = 1'b0;
    beat(1'b0, 4'b0101);
    beat(1'b0, 4'b1100);
    beat(1'b1, 4'b0101);
    beat(1'b1, 4'b1111);
    chk("t1_valid_lit", int'(a_out_valid), 1);
    chk("t1_acc_lit", int'(a_acc), 'h45);
    chk("t1_ovf_lit", int'(a_ovf), 0);
    // in_valid stays high while held; those beats must be ignored.
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 4'b1111);
      chk("t2_hold_acc_lit", int'(a_acc), 'h45);
      chk("t2_hold_ready_lit", int'(a_in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t2_release_valid_lit", int'(a_out_valid), 0);

    // Four beats of 31: 124 fits 8 bits but overflows 6 bits.
    for (int i = 0; i < 4; i++) beat(1'b1, 4'b1111);
    chk("t3_a_acc_lit", int'(a_acc), 'h7C);
`ifdef SATURATE_EN
    chk("t3_b_acc_lit", int'(b_acc), 'h3F);
`else
    chk("t3_b_acc_lit", int'(b_acc), 'h3C);
`endif
    chk("t3_b_ovf_lit", int'(b_ovf), 1);
    in_valid = 1'b0;
    step();

    // Clear after two beats, with a beat offered in the clear cycle.
    beat(1'b0, 4'b0111);
    beat(1'b0, 4'b0111);
    clear = 1'b1;
    beat(1'b0, 4'b0111);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b0, 4'b0001);
    chk("t4_acc_lit", int'(a_acc), 4);
    chk("t4_valid_lit", int'(a_out_valid), 1);
    in_valid = 1'b0;
    step();

    // Reset mid-frame.
    beat(1'b0, 4'b0011);
    beat(1'b0, 4'b0011);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mid_acc_lit", int'(a_acc), 0);
    chk("t5_mid_valid_lit", int'(a_out_valid), 0);
    step();
    rst_n = 1'b1;
    step();
    // Reset while holding a total.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b0, 4'b0011);
    in_valid = 1'b0;
    chk("t5_hold_acc_lit", int'(a_acc), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_hold_valid_lit", int'(a_out_valid), 0);
    chk("t5_hold_accz_lit", int'(a_acc), 0);
    chk("t5_hold_ovf_lit", int'(a_ovf), 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) beat(1'b0, 4'b0100);
    chk("t5_fresh_acc_lit", int'(a_acc), 16);
    in_valid = 1'b0;
    step();

    // Single-sample instance with random handshake gaps.
    for (int i = 0; i < 80; i++) begin
      c_valid     = 1'($urandom_range(0, 1));
      c_cout      = 1'($urandom_range(0, 1));
      c_sum       = 4'($urandom_range(0, 15));
      c_ready_out = 1'($urandom_range(0, 1));
      step();
    end
    c_valid     = 1'b0;
    c_ready_out = 1'b1;
    repeat (3) step();
    chk("t6_beat_count", c_outs, mc_accepts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
